tmr_mode_sequencer: RTL and testbench

Sequential mode controller for the dynamic TMR datapath. It accumulates error pulses into a windowed error rate and evaluates the 3-of-4 front/back proximity trigger. It then walks the redundant modules through simplex, warm-up, full-TMR and cool-down phases. It drives the module enables and tells the voter when the three copies are trustworthy, so spare modules are never voted on before they have settled, and TMR is never released on a single quiet cycle.

---
 rtl/tmr_mode_sequencer_if.sv | 23 ++
 rtl/tmr_mode_sequencer.sv | 128 ++++++++++++
 tb/tb_tmr_mode_sequencer.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/tmr_mode_sequencer_if.sv
// Handshake bundle between the TMR mode sequencer and its surroundings:
// proximity sensors and error pulses in, module enables and voter status out.
interface tmr_mode_sequencer_if;
    logic       f1;
    logic       f2;
    logic       b1;
    logic       b2;
    logic       err_pulse;
    logic [2:0] en;
    logic       tmr_active;
    logic [1:0] mode;
    logic [3:0] err_rate;

    modport master (
        output f1, f2, b1, b2, err_pulse,
        input  en, tmr_active, mode, err_rate
    );

    modport slave (
        input  f1, f2, b1, b2, err_pulse,
        output en, tmr_active, mode, err_rate
    );
endinterface

// File: rtl/tmr_mode_sequencer.sv
// Dynamic TMR mode controller: windowed error-rate measurement, 3-of-4
// proximity trigger, and a SIMPLEX/WARMUP/TMR/COOLDOWN sequencer that keeps
// the voter disabled until spare modules have settled.
module tmr_mode_sequencer #(
    parameter int WINDOW = 16,
    parameter int ERR_TH = 5,
    parameter int WARMUP = 4,
    parameter int HOLD   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    tmr_mode_sequencer_if.slave  bus
);

    localparam int WIN_W  = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam int WARM_W = (WARMUP > 1) ? $clog2(WARMUP) : 1;
    localparam int HOLD_W = (HOLD   > 1) ? $clog2(HOLD)   : 1;

    localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(WINDOW - 1);
    localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(WARMUP - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD - 1);
    localparam logic [3:0]        ERR_LIM   = 4'(ERR_TH);

    localparam logic [1:0] S_SIMPLEX  = 2'd0;
    localparam logic [1:0] S_WARMUP   = 2'd1;
    localparam logic [1:0] S_TMR      = 2'd2;
    localparam logic [1:0] S_COOLDOWN = 2'd3;

    // Add a single pulse to a 4-bit count, sticking at 15.
    function automatic logic [3:0] sat15(input logic [3:0] cnt, input logic inc);
        logic [4:0] sum;
        sum = {1'b0, cnt} + {4'b0000, inc};
        return sum[4] ? 4'hF : sum[3:0];
    endfunction

    logic [WIN_W-1:0]  win_cnt;
    logic [3:0]        mis_cnt;
    logic [3:0]        err_rate;
    logic [1:0]        state_q;
    logic [1:0]        state_n;
    logic [WARM_W-1:0] warm_cnt;
    logic [WARM_W-1:0] warm_n;
    logic [HOLD_W-1:0] hold_cnt;
    logic [HOLD_W-1:0] hold_n;
    logic [2:0]        en_q;
    logic              tmr_q;
    logic              sensor_hit;
    logic              trigger;

    assign sensor_hit = (bus.f2 & bus.b2 & (bus.f1 | bus.b1)) |
                        (bus.f1 & bus.b1 & (bus.f2 | bus.b2));
    assign trigger    = sensor_hit | (err_rate > ERR_LIM);

    // Free-running measurement window; a pulse on the closing cycle still counts.
    always_ff @(posedge clk) begin
        if (rst) begin
            win_cnt  <= '0;
            mis_cnt  <= '0;
            err_rate <= '0;
        end else if (win_cnt == WIN_LAST) begin
            win_cnt  <= '0;
            mis_cnt  <= '0;
            err_rate <= sat15(mis_cnt, bus.err_pulse);
        end else begin
            win_cnt  <= win_cnt + 1'b1;
            mis_cnt  <= sat15(mis_cnt, bus.err_pulse);
        end
    end

    // Next-state logic; warm-up ignores the trigger, cool-down needs HOLD quiet cycles.
    always_comb begin
        state_n = state_q;
        warm_n  = warm_cnt;
        hold_n  = hold_cnt;
        case (state_q)
            S_SIMPLEX: begin
                if (trigger) begin
                    state_n = S_WARMUP;
                    warm_n  = '0;
                end
            end
            S_WARMUP: begin
                if (warm_cnt == WARM_LAST) state_n = S_TMR;
                else                       warm_n  = warm_cnt + 1'b1;
            end
            S_TMR: begin
                if (!trigger) begin
                    state_n = S_COOLDOWN;
                    hold_n  = '0;
                end
            end
            S_COOLDOWN: begin
                if (trigger) begin
                    state_n = S_TMR;
                    hold_n  = '0;
                end else if (hold_cnt == HOLD_LAST) begin
                    state_n = S_SIMPLEX;
                end else begin
                    hold_n  = hold_cnt + 1'b1;
                end
            end
            default: state_n = S_SIMPLEX;
        endcase
    end

    // State and outputs decoded from the next state so they switch together with mode.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_SIMPLEX;
            warm_cnt <= '0;
            hold_cnt <= '0;
            en_q     <= 3'b001;
            tmr_q    <= 1'b0;
        end else begin
            state_q  <= state_n;
            warm_cnt <= warm_n;
            hold_cnt <= hold_n;
            en_q     <= (state_n == S_SIMPLEX) ? 3'b001 : 3'b111;
            tmr_q    <= (state_n == S_TMR) || (state_n == S_COOLDOWN);
        end
    end

    assign bus.en         = en_q;
    assign bus.tmr_active = tmr_q;
    assign bus.mode       = state_q;
    assign bus.err_rate   = err_rate;

endmodule

// File: tb/tb_tmr_mode_sequencer.sv
// Bench for tmr_mode_sequencer: directed test-plan scenarios plus randomized
// sensor/error traffic, all compared against a cycle-level behavioural model.
module tb_tmr_mode_sequencer;

    localparam int WINDOW = 16;
    localparam int ERR_TH = 5;
    localparam int WARMUP = 4;
    localparam int HOLD   = 8;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    tmr_mode_sequencer_if bus ();

    tmr_mode_sequencer #(
        .WINDOW(WINDOW), .ERR_TH(ERR_TH), .WARMUP(WARMUP), .HOLD(HOLD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Behavioural model: mode as a phase number, age = cycles spent in the phase,
    // error pulses counted as a plain integer per window and clipped when published.
    int m_mode, m_age, m_rate, m_pulses, m_cyc;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s observed=%0d expected=%0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge(input logic r, input logic [3:0] s, input logic ep);
        bit trig;
        if (r) begin
            m_mode = 0; m_age = 0; m_rate = 0; m_pulses = 0; m_cyc = 0;
            return;
        end
        trig = ($countones(s) >= 3) || (m_rate > ERR_TH);
        case (m_mode)
            0: if (trig) begin m_mode = 1; m_age = 1; end
            1: if (m_age == WARMUP) begin m_mode = 2; m_age = 1; end
               else m_age++;
            2: if (!trig) begin m_mode = 3; m_age = 1; end
            default: begin
                if (trig) begin m_mode = 2; m_age = 1; end
                else if (m_age == HOLD) begin m_mode = 0; m_age = 0; end
                else m_age++;
            end
        endcase
        if ((m_cyc % WINDOW) == WINDOW - 1) begin
            m_rate   = (m_pulses + ep > 15) ? 15 : m_pulses + ep;
            m_pulses = 0;
        end else begin
            m_pulses += ep;
        end
        m_cyc++;
    endtask

    // One clock: drive inputs, advance the model, sample on the falling edge.
    // s = {f1, f2, b1, b2}
    task automatic step(input logic r, input logic [3:0] s, input logic ep);
        rst           = r;
        bus.f1        = s[3];
        bus.f2        = s[2];
        bus.b1        = s[1];
        bus.b2        = s[0];
        bus.err_pulse = ep;
        model_edge(r, s, ep);
        @(posedge clk);
        @(negedge clk);
        chk("mode",       int'(bus.mode),       m_mode);
        chk("en",         int'(bus.en),         (m_mode == 0) ? 1 : 7);
        chk("tmr_active", int'(bus.tmr_active), (m_mode >= 2) ? 1 : 0);
        chk("err_rate",   int'(bus.err_rate),   m_rate);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 4'b0000, 1'b0);
    endtask

    initial begin
        logic [3:0] pat;
        int         dens;
        int         r;

        rst = 1'b1;
        bus.f1 = 0; bus.f2 = 0; bus.b1 = 0; bus.b2 = 0; bus.err_pulse = 0;

        // Reset state, held with quiet inputs.
        step(1'b1, 4'b0000, 1'b0);
        chk("rst_mode", int'(bus.mode), 0);
        chk("rst_en",   int'(bus.en),   1);
        chk("rst_tmr",  int'(bus.tmr_active), 0);
        chk("rst_rate", int'(bus.err_rate), 0);
        idle(40);
        chk("quiet40_mode", int'(bus.mode), 0);
        chk("quiet40_en",   int'(bus.en),   1);

        // Single 3-of-4 hit: full walk through the phases.
        step(1'b0, 4'b1110, 1'b0);
        chk("hit_warm_mode", int'(bus.mode), 1);
        chk("hit_warm_en",   int'(bus.en),   7);
        idle(4);
        chk("hit_tmr_mode",  int'(bus.mode), 2);
        chk("hit_tmr_act",   int'(bus.tmr_active), 1);
        idle(1);
        chk("hit_cool_mode", int'(bus.mode), 3);
        idle(7);
        chk("hit_cool_still", int'(bus.mode), 3);
        idle(1);
        chk("hit_back_mode", int'(bus.mode), 0);
        chk("hit_back_en",   int'(bus.en),   1);
        chk("hit_back_act",  int'(bus.tmr_active), 0);

        // Two of four sensors never trigger.
        for (int i = 0; i < 20; i++) step(1'b0, 4'b1100, 1'b0);
        chk("two_of_four_mode", int'(bus.mode), 0);
        chk("two_of_four_en",   int'(bus.en),   1);

        // Six pulses in window 0 -> rate 6 at cycle 16, WARMUP at cycle 17.
        step(1'b1, 4'b0000, 1'b0);
        for (int i = 0; i < 16; i++) step(1'b0, 4'b0000, (i < 6) ? 1'b1 : 1'b0);
        chk("rate6_value", int'(bus.err_rate), 6);
        chk("rate6_mode0", int'(bus.mode), 0);
        idle(1);
        chk("rate6_mode1", int'(bus.mode), 1);

        // Five pulses stay at threshold: no mode change.
        step(1'b1, 4'b0000, 1'b0);
        for (int i = 0; i < 16; i++) step(1'b0, 4'b0000, (i >= 11) ? 1'b1 : 1'b0);
        chk("rate5_value", int'(bus.err_rate), 5);
        idle(3);
        chk("rate5_mode", int'(bus.mode), 0);

        // Twenty consecutive pulses saturate the published rate.
        step(1'b1, 4'b0000, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b0, 4'b0000, 1'b1);
        chk("rate_sat", int'(bus.err_rate), 15);

        // Re-trigger in COOLDOWN restarts the full hold period.
        step(1'b1, 4'b0000, 1'b0);
        step(1'b0, 4'b1110, 1'b0);
        idle(5);
        chk("cool_enter", int'(bus.mode), 3);
        idle(5);
        step(1'b0, 4'b1011, 1'b0);
        chk("cool_retrig", int'(bus.mode), 2);
        idle(8);
        chk("cool_hold7", int'(bus.mode), 3);
        idle(1);
        chk("cool_done", int'(bus.mode), 0);

        // Reset in the second WARMUP cycle, then a full warm-up on the next trigger.
        step(1'b0, 4'b0111, 1'b0);
        idle(1);
        chk("warm2_mode", int'(bus.mode), 1);
        step(1'b1, 4'b0000, 1'b0);
        chk("warm_rst_mode", int'(bus.mode), 0);
        chk("warm_rst_en",   int'(bus.en), 1);
        step(1'b0, 4'b1101, 1'b0);
        idle(3);
        chk("rewarm_still", int'(bus.mode), 1);
        idle(1);
        chk("rewarm_tmr", int'(bus.mode), 2);

        // Randomized traffic with varying error density and rare resets.
        for (int seg = 0; seg < 6; seg++) begin
            case (seg % 4)
                0: dens = 0;
                1: dens = 25;
                2: dens = 45;
                default: dens = 75;
            endcase
            for (int i = 0; i < 500; i++) begin
                r   = $urandom_range(0, 99);
                pat = 4'($urandom_range(0, 15));
                if (r < 4) begin
                    pat = 4'b1111;
                    pat[$urandom_range(0, 3)] = 1'b0;
                end else if ($countones(pat) >= 3) begin
                    pat = pat & 4'b0101;
                end
                step(($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0, pat,
                     ($urandom_range(0, 99) < dens) ? 1'b1 : 1'b0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
